rau_req_sched: RTL and testbench

//  Sequences all RAU traffic: accepts warp register-allocation requests from TM (valid/ready) and warp-exit pulses from IB,

---
 rtl/rau_pkg.sv | 33 +++
 rtl/rau_exit_fifo.sv | 74 +++++++
 rtl/rau_req_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_rau_req_sched.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rau_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : rau_pkg                                                           |
// | Shared types and constants for the RAU request scheduler: FSM state         |
// | encoding, sticky-error bit positions and default widths.                    |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
package rau_pkg;

    localparam int c_num_warps_dflt    = 8;
    localparam int c_warp_w_dflt       = 3;
    localparam int c_nreq_w_dflt       = 3;
    localparam int c_avail_w_dflt      = 5;
    localparam int c_swwarp_w_dflt     = 32;
    localparam int c_done_timeout_dflt = 64;

    // Sticky error vector bit positions
    localparam int c_err_w         = 3;
    localparam int c_err_timeout   = 0;
    localparam int c_err_exit_drop = 1;
    localparam int c_err_allo_rej  = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOLD       = 3'd1,
        ST_ALLO_ISSUE = 3'd2,
        ST_ALLO_WAIT  = 3'd3,
        ST_EXIT_ISSUE = 3'd4,
        ST_EXIT_WAIT  = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rau_exit_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : rau_exit_fifo                                                     |
// | Synchronous FIFO holding hardware warp ids of pending exits.                |
// | Ports   : clk, rst (sync, active-high), push/din, pop/dout, empty, full.    |
// |           dout is valid whenever empty is low (first-word fall-through).    |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module rau_exit_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // The pending mask upstream limits occupancy to one entry per warp
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule
`default_nettype wire

// File: rtl/rau_req_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : rau_req_sched                                                     |
// | Serialises TM alloc requests and IB exit pulses into one-at-a-time RAU      |
// | AlloEN/ExitEN commands, exits first, waiting for RAU_Sched_Done (with       |
// | timeout). Allocs are held until RAU reports enough free registers.          |
// | Ports   : TM_Sched_*  alloc request (valid/ready), Sched_TM_AlloDone pulse  |
// |           IB_Sched_*  exit pulse + warp id                                  |
// |           Sched_RAU_* command strobes and payload, RAU_Sched_* response     |
// |           Sched_WarpActive per-warp register ownership, Sched_Err sticky    |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module rau_req_sched
    import rau_pkg::*;
#(
    parameter int NUM_WARPS    = c_num_warps_dflt,
    parameter int WARP_W       = c_warp_w_dflt,
    parameter int NREQ_W       = c_nreq_w_dflt,
    parameter int AVAIL_W      = c_avail_w_dflt,
    parameter int SWWARP_W     = c_swwarp_w_dflt,
    parameter int DONE_TIMEOUT = c_done_timeout_dflt
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 TM_Sched_AlloValid,
    input  logic [WARP_W-1:0]    TM_Sched_HWWarp,
    input  logic [SWWARP_W-1:0]  TM_Sched_SWWarp,
    input  logic [NREQ_W-1:0]    TM_Sched_Nreq,
    output logic                 Sched_TM_AlloReady,
    output logic                 Sched_TM_AlloDone,
    input  logic                 IB_Sched_ExitEN,
    input  logic [WARP_W-1:0]    IB_Sched_ExitWarpID,
    output logic                 Sched_RAU_AlloEN,
    output logic                 Sched_RAU_ExitEN,
    output logic [WARP_W-1:0]    Sched_RAU_HWWarp,
    output logic [SWWARP_W-1:0]  Sched_RAU_SWWarp,
    output logic [NREQ_W-1:0]    Sched_RAU_Nreq,
    input  logic                 RAU_Sched_Done,
    input  logic [AVAIL_W-1:0]   RAU_Sched_Available,
    output logic [NUM_WARPS-1:0] Sched_WarpActive,
    output logic [2:0]           Sched_Err
);

    localparam int c_cnt_w = $clog2(DONE_TIMEOUT + 1);
    localparam int c_cmp_w = (AVAIL_W > NREQ_W) ? AVAIL_W : NREQ_W;
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(DONE_TIMEOUT - 1);
    localparam logic [NUM_WARPS-1:0] c_one      = NUM_WARPS'(1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [WARP_W-1:0]     r_hold_warp;
    logic [SWWARP_W-1:0]   r_hold_sw;
    logic [NREQ_W-1:0]     r_hold_nreq;
    logic                  r_hold_valid;
    logic [WARP_W-1:0]     r_exit_warp;
    logic [NUM_WARPS-1:0]  r_active;
    logic [NUM_WARPS-1:0]  r_pending;
    logic [c_cnt_w-1:0]    r_wait_cnt;
    logic                  r_allo_done;
    logic [c_err_w-1:0]    r_err;

    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_fifo_pop;
    logic                  w_fifo_push;
    logic [WARP_W-1:0]     w_fifo_dout;
    logic                  w_allo_take;
    logic                  w_allo_reject;
    logic                  w_allo_commit;
    logic                  w_allo_finish;
    logic                  w_exit_finish;
    logic                  w_exit_clear;
    logic                  w_timeout;
    logic                  w_wait_expired;
    logic                  w_avail_ok;

    // An exit is accepted only for a warp that owns registers and has no exit queued
    assign w_fifo_push    = IB_Sched_ExitEN && r_active[IB_Sched_ExitWarpID]
                            && !r_pending[IB_Sched_ExitWarpID] && !w_fifo_full;
    assign w_wait_expired = (r_wait_cnt == c_cnt_last);
    assign w_avail_ok     = (c_cmp_w'(RAU_Sched_Available) >= c_cmp_w'(r_hold_nreq));

    rau_exit_fifo #(
        .WIDTH (WARP_W),
        .DEPTH (NUM_WARPS)
    ) u_exit_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .din   (IB_Sched_ExitWarpID),
        .pop   (w_fifo_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_fifo_pop    = 1'b0;
        w_allo_take   = 1'b0;
        w_allo_reject = 1'b0;
        w_allo_commit = 1'b0;
        w_allo_finish = 1'b0;
        w_exit_finish = 1'b0;
        w_exit_clear  = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = ST_EXIT_ISSUE;
                end else if (TM_Sched_AlloValid) begin
                    if (r_active[TM_Sched_HWWarp]) begin
                        w_allo_reject = 1'b1;
                    end else begin
                        w_allo_take = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Exits overtake a held alloc; the alloc resumes afterwards
                if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = ST_EXIT_ISSUE;
                end else if (r_hold_nreq == '0) begin
                    w_allo_commit = 1'b1;
                    w_allo_finish = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_avail_ok) begin
                    w_state_nxt = ST_ALLO_ISSUE;
                end
            end
            ST_ALLO_ISSUE: w_state_nxt = ST_ALLO_WAIT;
            ST_ALLO_WAIT: begin
                if (RAU_Sched_Done) begin
                    w_allo_commit = 1'b1;
                    w_allo_finish = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_wait_expired) begin
                    w_timeout     = 1'b1;
                    w_allo_finish = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_EXIT_ISSUE: w_state_nxt = ST_EXIT_WAIT;
            ST_EXIT_WAIT: begin
                if (RAU_Sched_Done || w_wait_expired) begin
                    w_exit_finish = 1'b1;
                    w_exit_clear  = RAU_Sched_Done;
                    w_timeout     = !RAU_Sched_Done;
                    w_state_nxt   = r_hold_valid ? ST_HOLD : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold_warp  <= '0;
            r_hold_sw    <= '0;
            r_hold_nreq  <= '0;
            r_hold_valid <= 1'b0;
            r_exit_warp  <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_wait_cnt   <= '0;
            r_allo_done  <= 1'b0;
            r_err        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_allo_done <= w_allo_commit;

            if (w_allo_take) begin
                r_hold_warp  <= TM_Sched_HWWarp;
                r_hold_sw    <= TM_Sched_SWWarp;
                r_hold_nreq  <= TM_Sched_Nreq;
                r_hold_valid <= 1'b1;
            end else if (w_allo_finish) begin
                r_hold_valid <= 1'b0;
            end

            if (w_fifo_pop) begin
                r_exit_warp <= w_fifo_dout;
            end

            r_active  <= (r_active | (w_allo_commit ? (c_one << r_hold_warp) : '0))
                         & ~(w_exit_clear ? (c_one << r_exit_warp) : '0);
            r_pending <= (r_pending | (w_fifo_push ? (c_one << IB_Sched_ExitWarpID) : '0))
                         & ~(w_exit_finish ? (c_one << r_exit_warp) : '0);

            if (r_state == ST_ALLO_ISSUE || r_state == ST_EXIT_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_ALLO_WAIT || r_state == ST_EXIT_WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
            end

            if (w_timeout) begin
                r_err[c_err_timeout] <= 1'b1;
            end
            if (IB_Sched_ExitEN && !w_fifo_push) begin
                r_err[c_err_exit_drop] <= 1'b1;
            end
            if (w_allo_reject) begin
                r_err[c_err_allo_rej] <= 1'b1;
            end
        end
    end

    assign Sched_TM_AlloReady = (r_state == ST_IDLE) && w_fifo_empty;
    assign Sched_TM_AlloDone  = r_allo_done;
    assign Sched_RAU_AlloEN   = (r_state == ST_ALLO_ISSUE);
    assign Sched_RAU_ExitEN   = (r_state == ST_EXIT_ISSUE);
    assign Sched_RAU_HWWarp   = (r_state == ST_EXIT_ISSUE || r_state == ST_EXIT_WAIT)
                                ? r_exit_warp : r_hold_warp;
    assign Sched_RAU_SWWarp   = r_hold_sw;
    assign Sched_RAU_Nreq     = r_hold_nreq;
    assign Sched_WarpActive   = r_active;
    assign Sched_Err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rau_req_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_rau_req_sched                                                  |
// | Self-checking bench for rau_req_sched: directed scenarios followed by a     |
// | randomized sequence of alloc/exit operations against a warp-ownership model.|
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_rau_req_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        TM_Sched_AlloValid;
    logic [2:0]  TM_Sched_HWWarp;
    logic [31:0] TM_Sched_SWWarp;
    logic [2:0]  TM_Sched_Nreq;
    logic        Sched_TM_AlloReady;
    logic        Sched_TM_AlloDone;
    logic        IB_Sched_ExitEN;
    logic [2:0]  IB_Sched_ExitWarpID;
    logic        Sched_RAU_AlloEN;
    logic        Sched_RAU_ExitEN;
    logic [2:0]  Sched_RAU_HWWarp;
    logic [31:0] Sched_RAU_SWWarp;
    logic [2:0]  Sched_RAU_Nreq;
    logic        RAU_Sched_Done;
    logic [4:0]  RAU_Sched_Available;
    logic [7:0]  Sched_WarpActive;
    logic [2:0]  Sched_Err;

    rau_req_sched dut (
        .clk                 (clk),
        .rst                 (rst),
        .TM_Sched_AlloValid  (TM_Sched_AlloValid),
        .TM_Sched_HWWarp     (TM_Sched_HWWarp),
        .TM_Sched_SWWarp     (TM_Sched_SWWarp),
        .TM_Sched_Nreq       (TM_Sched_Nreq),
        .Sched_TM_AlloReady  (Sched_TM_AlloReady),
        .Sched_TM_AlloDone   (Sched_TM_AlloDone),
        .IB_Sched_ExitEN     (IB_Sched_ExitEN),
        .IB_Sched_ExitWarpID (IB_Sched_ExitWarpID),
        .Sched_RAU_AlloEN    (Sched_RAU_AlloEN),
        .Sched_RAU_ExitEN    (Sched_RAU_ExitEN),
        .Sched_RAU_HWWarp    (Sched_RAU_HWWarp),
        .Sched_RAU_SWWarp    (Sched_RAU_SWWarp),
        .Sched_RAU_Nreq      (Sched_RAU_Nreq),
        .RAU_Sched_Done      (RAU_Sched_Done),
        .RAU_Sched_Available (RAU_Sched_Available),
        .Sched_WarpActive    (Sched_WarpActive),
        .Sched_Err           (Sched_Err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    // Reference model: which warps own registers, and the sticky error flags
    logic [7:0] m_active = 8'h00;
    logic [2:0] m_err    = 3'b000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_model;
        chk("warp_active", 64'(Sched_WarpActive), 64'(m_active));
        chk("err", 64'(Sched_Err), 64'(m_err));
    endtask

    // Full alloc transaction from an idle scheduler; RAU answers dly cycles into the wait
    task automatic alloc_op(input int w, input int nreq, input int avail, input int dly);
        logic [31:0] sw;
        int          saw;
        sw = $urandom();
        chk("allo_ready", 64'(Sched_TM_AlloReady), 64'd1);
        RAU_Sched_Available = 5'(avail);
        TM_Sched_AlloValid  = 1'b1;
        TM_Sched_HWWarp     = 3'(w);
        TM_Sched_SWWarp     = sw;
        TM_Sched_Nreq       = 3'(nreq);
        tick;
        TM_Sched_AlloValid  = 1'b0;
        if (m_active[w]) begin
            m_err[2] = 1'b1;
            saw = 0;
            repeat (3) begin
                if (Sched_RAU_AlloEN) saw = 1;
                tick;
            end
            chk("rej_no_alloen", 64'(saw), 64'd0);
        end else if (nreq == 0) begin
            chk("zero_no_alloen", 64'(Sched_RAU_AlloEN), 64'd0);
            tick;
            chk("zero_allodone", 64'(Sched_TM_AlloDone), 64'd1);
            m_active[w] = 1'b1;
        end else begin
            if (avail < nreq) begin
                saw = 0;
                repeat (3) begin
                    tick;
                    if (Sched_RAU_AlloEN) saw = 1;
                end
                chk("hold_no_alloen", 64'(saw), 64'd0);
                RAU_Sched_Available = 5'd31;
            end
            tick;
            chk("alloen", 64'(Sched_RAU_AlloEN), 64'd1);
            chk("allo_hwwarp", 64'(Sched_RAU_HWWarp), 64'(w));
            chk("allo_swwarp", 64'(Sched_RAU_SWWarp), 64'(sw));
            chk("allo_nreq", 64'(Sched_RAU_Nreq), 64'(nreq));
            tick;
            saw = 0;
            repeat (dly) begin
                if (Sched_RAU_AlloEN || Sched_RAU_HWWarp != 3'(w) || Sched_TM_AlloDone) saw = 1;
                tick;
            end
            chk("allo_wait_stable", 64'(saw), 64'd0);
            RAU_Sched_Done = 1'b1;
            tick;
            RAU_Sched_Done = 1'b0;
            chk("allodone", 64'(Sched_TM_AlloDone), 64'd1);
            m_active[w] = 1'b1;
        end
        chk_model();
    endtask

    // Full exit transaction from an idle scheduler
    task automatic exit_op(input int w, input int dly);
        int saw;
        IB_Sched_ExitEN     = 1'b1;
        IB_Sched_ExitWarpID = 3'(w);
        tick;
        IB_Sched_ExitEN     = 1'b0;
        if (!m_active[w]) begin
            m_err[1] = 1'b1;
            saw = 0;
            repeat (3) begin
                if (Sched_RAU_ExitEN) saw = 1;
                tick;
            end
            chk("drop_no_exiten", 64'(saw), 64'd0);
        end else begin
            tick;
            chk("exiten", 64'(Sched_RAU_ExitEN), 64'd1);
            chk("exit_hwwarp", 64'(Sched_RAU_HWWarp), 64'(w));
            tick;
            saw = 0;
            repeat (dly) begin
                if (Sched_RAU_ExitEN || Sched_RAU_HWWarp != 3'(w)) saw = 1;
                tick;
            end
            chk("exit_wait_stable", 64'(saw), 64'd0);
            RAU_Sched_Done = 1'b1;
            tick;
            RAU_Sched_Done = 1'b0;
            m_active[w] = 1'b0;
            chk("exit_ready", 64'(Sched_TM_AlloReady), 64'd1);
        end
        chk_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         saw;
        int         n;
        logic       pend_done;
        logic [2:0] got [$];
        logic [31:0] sw;

        rst                 = 1'b1;
        TM_Sched_AlloValid  = 1'b0;
        TM_Sched_HWWarp     = '0;
        TM_Sched_SWWarp     = '0;
        TM_Sched_Nreq       = '0;
        IB_Sched_ExitEN     = 1'b0;
        IB_Sched_ExitWarpID = '0;
        RAU_Sched_Done      = 1'b0;
        RAU_Sched_Available = '0;
        repeat (3) tick;
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 64'(Sched_TM_AlloReady), 64'd1);
        chk("rst_alloen", 64'(Sched_RAU_AlloEN), 64'd0);
        chk("rst_exiten", 64'(Sched_RAU_ExitEN), 64'd0);
        chk("rst_allodone", 64'(Sched_TM_AlloDone), 64'd0);
        chk_model();

        // 1: alloc w3 Nreq=4 with Available=10
        alloc_op(3, 4, 10, 2);
        chk("t1_active", 64'(Sched_WarpActive), 64'h08);
        tick;
        chk("t1_allodone_1cyc", 64'(Sched_TM_AlloDone), 64'd0);

        // 2+3: alloc w1 Nreq=6 held on Available=4, exit w3 overtakes it
        sw = $urandom();
        RAU_Sched_Available = 5'd4;
        TM_Sched_AlloValid  = 1'b1;
        TM_Sched_HWWarp     = 3'd1;
        TM_Sched_SWWarp     = sw;
        TM_Sched_Nreq       = 3'd6;
        tick;
        TM_Sched_AlloValid  = 1'b0;
        saw = 0;
        repeat (3) begin
            tick;
            if (Sched_RAU_AlloEN) saw = 1;
        end
        chk("t2_held", 64'(saw), 64'd0);
        IB_Sched_ExitEN     = 1'b1;
        IB_Sched_ExitWarpID = 3'd3;
        tick;
        IB_Sched_ExitEN     = 1'b0;
        tick;
        chk("t3_exiten", 64'(Sched_RAU_ExitEN), 64'd1);
        chk("t3_exit_warp", 64'(Sched_RAU_HWWarp), 64'd3);
        chk("t3_no_alloen", 64'(Sched_RAU_AlloEN), 64'd0);
        tick;
        RAU_Sched_Done = 1'b1;
        tick;
        RAU_Sched_Done = 1'b0;
        m_active[3] = 1'b0;
        chk("t3_exit_cleared", 64'(Sched_WarpActive), 64'(m_active));
        chk("t3_still_held", 64'(Sched_RAU_AlloEN), 64'd0);
        RAU_Sched_Available = 5'd6;
        tick;
        chk("t2_alloen", 64'(Sched_RAU_AlloEN), 64'd1);
        chk("t2_warp", 64'(Sched_RAU_HWWarp), 64'd1);
        chk("t2_nreq", 64'(Sched_RAU_Nreq), 64'd6);
        chk("t2_sw", 64'(Sched_RAU_SWWarp), 64'(sw));
        tick;
        RAU_Sched_Done = 1'b1;
        tick;
        RAU_Sched_Done = 1'b0;
        chk("t2_allodone", 64'(Sched_TM_AlloDone), 64'd1);
        m_active[1] = 1'b1;
        chk_model();

        // 4: exits w2, w5 then duplicate w2 on consecutive cycles
        alloc_op(2, 3, 31, 0);
        alloc_op(5, 1, 31, 1);
        pend_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            IB_Sched_ExitEN     = (i < 3);
            IB_Sched_ExitWarpID = (i == 1) ? 3'd5 : 3'd2;
            RAU_Sched_Done      = pend_done;
            pend_done           = 1'b0;
            if (Sched_RAU_ExitEN) begin
                got.push_back(Sched_RAU_HWWarp);
                pend_done = 1'b1;
            end
            tick;
        end
        IB_Sched_ExitEN = 1'b0;
        RAU_Sched_Done  = 1'b0;
        m_active[2] = 1'b0;
        m_active[5] = 1'b0;
        m_err[1]    = 1'b1;
        chk("t4_exit_count", 64'(got.size()), 64'd2);
        chk("t4_first", 64'((got.size() > 0) ? got[0] : 3'd7), 64'd2);
        chk("t4_second", 64'((got.size() > 1) ? got[1] : 3'd7), 64'd5);
        chk_model();

        // 5: alloc to an already active warp is rejected
        alloc_op(3, 2, 31, 1);
        alloc_op(3, 2, 31, 1);

        // 6a: RAU never answers an alloc
        RAU_Sched_Available = 5'd31;
        TM_Sched_AlloValid  = 1'b1;
        TM_Sched_HWWarp     = 3'd6;
        TM_Sched_Nreq       = 3'd3;
        tick;
        TM_Sched_AlloValid  = 1'b0;
        tick;
        chk("t6_alloen", 64'(Sched_RAU_AlloEN), 64'd1);
        n = 0;
        while (!Sched_Err[0] && n < 100) begin
            tick;
            n++;
        end
        m_err[0] = 1'b1;
        chk("t6_timeout_cycles", 64'(n), 64'd65);
        chk("t6_idle", 64'(Sched_TM_AlloReady), 64'd1);
        chk_model();

        // 6b: reset in the middle of an alloc wait
        TM_Sched_AlloValid = 1'b1;
        TM_Sched_HWWarp    = 3'd7;
        TM_Sched_Nreq      = 3'd2;
        TM_Sched_SWWarp    = 32'hA5A5_0007;
        tick;
        TM_Sched_AlloValid = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_active = 8'h00;
        m_err    = 3'b000;
        chk("t6_rst_alloen", 64'(Sched_RAU_AlloEN), 64'd0);
        chk("t6_rst_exiten", 64'(Sched_RAU_ExitEN), 64'd0);
        chk("t6_rst_allodone", 64'(Sched_TM_AlloDone), 64'd0);
        chk("t6_rst_payload", {29'd0, Sched_RAU_HWWarp, Sched_RAU_SWWarp}, 64'd0);
        chk("t6_rst_nreq", 64'(Sched_RAU_Nreq), 64'd0);
        chk("t6_rst_ready", 64'(Sched_TM_AlloReady), 64'd1);
        chk_model();
        tick;
        chk("t6_rst_no_done", 64'(Sched_TM_AlloDone), 64'd0);

        // Randomized operations against the ownership model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                alloc_op($urandom_range(7, 0), $urandom_range(7, 0),
                         $urandom_range(31, 0), $urandom_range(5, 0));
            end else begin
                exit_op($urandom_range(7, 0), $urandom_range(5, 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
